// File: rtl/fre_meas_pkg.sv
// Shared types and constants for the fre_meas frequency/duty-cycle meter.
package fre_meas_pkg;

   localparam int FRE_MEAS_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_t;

endpackage

// File: rtl/fre_meas_if.sv
// Control/result bundle of fre_meas. The meter is the slave: it takes en and
// sig_in and returns the registered measurement results.
interface fre_meas_if
   import fre_meas_pkg::*;
#(
   parameter int W = FRE_MEAS_W_DEF
) ();

   logic         en;
   logic         sig_in;
   logic         meas_valid;
   logic [W-1:0] meas_hw;
   logic [W-1:0] meas_lw;
   logic [W:0]   meas_period;
   logic         meas_ovf;
   logic         busy;

   modport master (
      output en, sig_in,
      input  meas_valid, meas_hw, meas_lw, meas_period, meas_ovf, busy
   );

   modport slave (
      input  en, sig_in,
      output meas_valid, meas_hw, meas_lw, meas_period, meas_ovf, busy
   );

endinterface

// File: rtl/fre_meas_sync_2ff.sv
// Generic 1-bit two-flop synchronizer, async active-high reset, resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops give the first stage a full cycle to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/fre_meas.sv
// Frequency/duty-cycle meter: measures high width, low width and period of each
// complete cycle of sig_in in clk cycles and reports them with a one-cycle strobe.
// Build option: define FRE_MEAS_SYNC_EN to pass sig_in through a two-flop
// synchronizer (asynchronous sig_in allowed, +2 cycles latency).
//
// state | meaning
// IDLE  | disabled or just enabled; waiting for sig low to drop any partial period
// ARM   | sig seen low; waiting for the first rising edge
// HIGH  | counting the high phase of the current period
// LOW   | counting the low phase; next rising edge publishes the result
module fre_meas
   import fre_meas_pkg::*;
#(
   parameter int W = FRE_MEAS_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   fre_meas_if.slave  bus
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic         sig;
   state_t       state;
   logic [W-1:0] hcnt;
   logic [W-1:0] lcnt;
   logic         ovf;

`ifdef FRE_MEAS_SYNC_EN
   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.sig_in),
      .q   (sig)
   );
`else
   assign sig = bus.sig_in;
`endif

   // FSM, saturating phase counters and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         hcnt            <= '0;
         lcnt            <= '0;
         ovf             <= 1'b0;
         bus.meas_valid  <= 1'b0;
         bus.meas_hw     <= '0;
         bus.meas_lw     <= '0;
         bus.meas_period <= '0;
         bus.meas_ovf    <= 1'b0;
         bus.busy        <= 1'b0;
      end else begin
         bus.meas_valid <= 1'b0;
         if (!bus.en) begin
            state    <= IDLE;
            hcnt     <= '0;
            lcnt     <= '0;
            ovf      <= 1'b0;
            bus.busy <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  bus.busy <= 1'b0;
                  if (!sig) state <= ARM;
               end
               ARM: begin
                  if (sig) begin
                     hcnt     <= W'(1);
                     lcnt     <= '0;
                     ovf      <= 1'b0;
                     bus.busy <= 1'b1;
                     state    <= HIGH;
                  end
               end
               HIGH: begin
                  if (sig) begin
                     if (hcnt != CNT_MAX) hcnt <= hcnt + 1'b1;
                     if (hcnt >= CNT_MAX - 1'b1) ovf <= 1'b1;
                  end else begin
                     lcnt  <= W'(1);
                     state <= LOW;
                  end
               end
               LOW: begin
                  if (!sig) begin
                     if (lcnt != CNT_MAX) lcnt <= lcnt + 1'b1;
                     if (lcnt >= CNT_MAX - 1'b1) ovf <= 1'b1;
                  end else begin
                     bus.meas_hw     <= hcnt;
                     bus.meas_lw     <= lcnt;
                     bus.meas_period <= {1'b0, hcnt} + {1'b0, lcnt};
                     bus.meas_ovf    <= ovf;
                     bus.meas_valid  <= 1'b1;
                     hcnt            <= W'(1);
                     lcnt            <= '0;
                     ovf             <= 1'b0;
                     state           <= HIGH;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
